mem_ctrl: RTL
=============

# mem_ctrl

- Multi-cycle data-memory controller sitting directly downstream of the combinational MEM stage.
- Accepts the MEM stage's 32-bit request (chip enable, write enable, byte selects, address, lane-replicated store data).
- Serialises the request into byte accesses on an 8-bit synchronous RAM port shared through an arbiter, and reassembles load data into a 32-bit word.
- Stalls the pipeline until the access completes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- mem_ce_i  in  1  request valid from MEM stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_sel_i  in  4  byte-lane selects, bit k = lane k (bits 8k+7:8k)
- mem_addr_i  in  32  byte address; the word base is {mem_addr_i[31:2],2'b00}
- mem_data_i  in  32  store data, already replicated across lanes
- mem_data_o  out  32  assembled load word, lane-aligned, back to MEM stage
- stallreq_o  out  1  pipeline stall request
- ram_gnt_i  in  1  arbiter grant for this cycle's RAM issue
- ram_addr_o  out  32  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte; the read issued in cycle t is valid during t+1

## Operation
- States:
  - IDLE: no request in progress.
  - ACCESS: issuing byte accesses; lane counter k.
  - DRAIN: capturing the final read byte.
  - DONE: one cycle presenting the result.
- IDLE with mem_ce_i=1:
  - Latch we, sel, word base and data.
  - Clear mem_data_o to 0.
  - Set k to the first lane to access.
  - Go to ACCESS.
- ACCESS:
  - Drive ram_addr_o = base + k and ram_dout_o = latched data[8k+7:8k].
  - Drive ram_wr_o = we & sel[k].
  - An issue counts only in cycles with ram_gnt_i=1. When ram_gnt_i=0, hold k and all RAM outputs unchanged.
  - On a counted issue of a read, record the pending lane = k.
  - After the last lane issues: go to DRAIN if that issue was a read, else go to DONE.
- Any cycle following a counted read issue: write ram_din_i into mem_data_o lane = pending lane at the clock edge. This applies in ACCESS and DRAIN, independent of ram_gnt_i.
- DRAIN: capture the final byte, then go to DONE.
- DONE: stallreq_o=0 and mem_data_o valid; go to IDLE unconditionally. The request still present on mem_ce_i in this cycle is not re-accepted.
- stallreq_o = (IDLE & mem_ce_i) | ACCESS | DRAIN. It is combinational so the stall begins in the request cycle.
- Outside ACCESS: ram_addr_o=0, ram_wr_o=0, ram_dout_o=0.
- A store with an unselected lane never writes that lane.

## Timing
- Reset (asynchronous, rst=0): immediately force IDLE, k=0, no pending capture; mem_data_o=0, stallreq_o=0, ram_addr_o=0, ram_wr_o=0, ram_dout_o=0.
- A reset mid-access abandons the access; a write strobe drops the same instant.
- Full-word load, grant always 1, request seen in cycle 0:
  - ACCESS in cycles 1-4 (lanes 0-3).
  - DRAIN in cycle 5.
  - DONE in cycle 6; stallreq_o is high in cycles 0-5.
- Full-word store, grant always 1: ACCESS in cycles 1-4, DONE in cycle 5.
- Each grant-low cycle during ACCESS adds exactly one cycle of latency.
- Back-to-back requests: a new request is sampled in the IDLE cycle after DONE, so there is a minimum of one idle cycle between requests.
- mem_sel_i=0 with mem_ce_i=1:
  - MEM_CTRL_BYTE_SKIP_EN defined: no lanes are accessed; IDLE goes straight to DONE in the next cycle.
  - Macro undefined: the request is handled as below.

## Configuration
- MEM_CTRL_BYTE_SKIP_EN defined:
  - ACCESS visits only lanes with sel[k]=1, in ascending order.
  - Unselected load lanes of mem_data_o remain 0.
- Macro undefined:
  - Every request visits all four lanes 0-3.
  - A store issues reads (ram_wr_o=0) on unselected lanes and discards the data. If lane 3 is such a read, go directly to DONE with no DRAIN.
  - A load returns all four bytes regardless of sel.

## Test plan
- Word load at 0x100, RAM bytes 11,22,33,44, grant 1 → mem_data_o=0x44332211 in cycle 6, stallreq_o high in cycles 0-5.
- SW 0xDEADBEEF to 0x200, grant 1 → writes EF,BE,AD,DE to 0x200-0x203 in cycles 1-4, DONE in cycle 5.
- SB at 0x1003, sel=1000, data 0x5A5A5A5A:
  - With the macro: one write of 5A to 0x1003 in cycle 1, DONE in cycle 2.
  - Without the macro: reads in cycles 1-3, write in cycle 4, DONE in cycle 5.
- LB at 0x1001 with the macro, RAM[0x1001]=0x80 → mem_data_o=0x00008000 in cycle 3.
- Word load with ram_gnt_i low in cycles 2-3 → lane-1 address held for 3 cycles, DONE in cycle 8, data still correct.
- Assert rst=0 during cycle 3 of a store → ram_wr_o drops immediately, state IDLE, all outputs 0; a fresh load after release completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Data-memory controller: splits a 32-bit MEM-stage request into byte accesses on an 8-bit RAM port.
// Latency: with grant always high, a word load takes 6 stall cycles and a word store 5; DONE follows.
// Backpressure: a grant-low cycle holds the lane and RAM outputs. Optional lane skipping via MEM_CTRL_BYTE_SKIP_EN.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stallreq_o,
   input  logic        ram_gnt_i,
   output logic [31:0] ram_addr_o,
   output logic        ram_wr_o,
   output logic [7:0]  ram_dout_o,
   input  logic [7:0]  ram_din_i
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [29:0] word_q, word_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  k_q, k_d;
   logic        pend_vld_q, pend_vld_d;
   logic [1:0]  pend_lane_q, pend_lane_d;
   logic [31:0] mem_data_q, mem_data_d;

   logic        in_access;
   logic        wr_now;
   logic        lane_last;
   logic [1:0]  lane_next;

   // Byte offset within the word is implied by the lane counter, so the low address bits are not needed.
   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^mem_addr_i[1:0];

`ifdef MEM_CTRL_BYTE_SKIP_EN
   logic [2:0]  first_lane;
   logic [2:0]  after_lane;

   // Lowest selected lane at or above start; bit 2 flags that one exists.
   function automatic logic [2:0] find_lane(input logic [3:0] sel, input logic [2:0] start);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (i >= int'(start) && sel[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction
`endif

   assign in_access = (state_q == S_ACCESS);
   assign wr_now    = we_q & sel_q[k_q];

   // RAM port is idle-zero outside ACCESS; while ungranted the lane counter holds, so these hold too.
   assign ram_addr_o = in_access ? {word_q, k_q} : 32'd0;
   assign ram_wr_o   = in_access & wr_now;
   assign ram_dout_o = in_access ? wdata_q[8*k_q +: 8] : 8'd0;

   // Stall starts combinationally in the request cycle and is forced low while in reset.
   assign stallreq_o = rst & (((state_q == S_IDLE) & mem_ce_i) | in_access | (state_q == S_DRAIN));
   assign mem_data_o = mem_data_q;

   // Next-lane selection: every lane in order, or only selected lanes when skipping is enabled.
   always_comb begin
`ifdef MEM_CTRL_BYTE_SKIP_EN
      first_lane = find_lane(mem_sel_i, 3'd0);
      after_lane = find_lane(sel_q, {1'b0, k_q} + 3'd1);
      lane_last  = ~after_lane[2];
      lane_next  = after_lane[1:0];
`else
      lane_last  = (k_q == 2'd3);
      lane_next  = k_q + 2'd1;
`endif
   end

   // Request sequencing, lane stepping and load-byte reassembly.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      sel_d       = sel_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      k_d         = k_q;
      pend_vld_d  = 1'b0;
      pend_lane_d = pend_lane_q;
      mem_data_d  = mem_data_q;

      // The byte read last cycle is on ram_din_i now, whatever the grant does.
      if (pend_vld_q) mem_data_d[8*pend_lane_q +: 8] = ram_din_i;

      case (state_q)
         S_IDLE: begin
            if (mem_ce_i) begin
               we_d       = mem_we_i;
               sel_d      = mem_sel_i;
               word_d     = mem_addr_i[31:2];
               wdata_d    = mem_data_i;
               mem_data_d = 32'd0;
`ifdef MEM_CTRL_BYTE_SKIP_EN
               if (first_lane[2]) begin
                  k_d     = first_lane[1:0];
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_DONE;
               end
`else
               k_d     = 2'd0;
               state_d = S_ACCESS;
`endif
            end
         end
         S_ACCESS: begin
            if (ram_gnt_i) begin
               // Only load reads are captured; filler reads of a store are discarded.
               if (!wr_now) begin
                  pend_vld_d  = ~we_q;
                  pend_lane_d = k_q;
               end
               if (lane_last) state_d = we_q ? S_DONE : S_DRAIN;
               else           k_d     = lane_next;
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with asynchronous reset abandoning any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         sel_q       <= 4'd0;
         word_q      <= 30'd0;
         wdata_q     <= 32'd0;
         k_q         <= 2'd0;
         pend_vld_q  <= 1'b0;
         pend_lane_q <= 2'd0;
         mem_data_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         k_q         <= k_d;
         pend_vld_q  <= pend_vld_d;
         pend_lane_q <= pend_lane_d;
         mem_data_q  <= mem_data_d;
      end
   end

endmodule
